// File: rtl/interrupt_ctrl_pkg.sv
// interrupt_ctrl_pkg: register offsets, cause codes, FSM states and priority helper
package interrupt_ctrl_pkg;
  localparam logic [4:0] ADDR_MSIP    = 5'h00;
  localparam logic [4:0] ADDR_EXT     = 5'h04;
  localparam logic [4:0] ADDR_CMP_LO  = 5'h08;
  localparam logic [4:0] ADDR_CMP_HI  = 5'h0C;
  localparam logic [4:0] ADDR_TIME_LO = 5'h10;
  localparam logic [4:0] ADDR_TIME_HI = 5'h14;
  localparam logic [4:0] ADDR_EN      = 5'h18;
  localparam logic [30:0] CAUSE_SOFT  = 31'd3;
  localparam logic [30:0] CAUSE_TIMER = 31'd7;
  localparam logic [30:0] CAUSE_EXT   = 31'd11;
  typedef enum logic [1:0] {IDLE, REQ, TRAP} state_t;
  // pend = {ext, timer, soft}; ext beats soft beats timer
  function automatic logic [30:0] top_cause(input logic [2:0] pend);
    return pend[2] ? CAUSE_EXT : pend[0] ? CAUSE_SOFT : pend[1] ? CAUSE_TIMER : 31'd0;
  endfunction
endpackage

// File: rtl/intc_timer.sv
// intc_timer: 64-bit mtime with prescaler, mtimecmp and level compare
module intc_timer
  import interrupt_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        pending
);
  logic [15:0] pre;
  logic        tick;
  assign tick    = pre == 16'(PRESCALE - 1);
  assign pending = mtime >= mtimecmp;
  // register writes; a write to either mtime half replaces the increment and restarts the prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      pre      <= '0;
    end else begin
      if (wr_en && wr_addr == ADDR_CMP_LO) mtimecmp[31:0] <= wr_data;
      if (wr_en && wr_addr == ADDR_CMP_HI) mtimecmp[63:32] <= wr_data;
      if (wr_en && wr_addr == ADDR_TIME_LO) begin
        mtime[31:0] <= wr_data;
        pre         <= '0;
      end else if (wr_en && wr_addr == ADDR_TIME_HI) begin
        mtime[63:32] <= wr_data;
        pre          <= '0;
      end else begin
        pre <= tick ? '0 : pre + 16'd1;
        if (tick) mtime <= mtime + 64'd1;
      end
    end
  end
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: machine-mode interrupt controller (soft/timer/ext); INTC_EXT_SYNC_EN adds a 2-flop ext_irq synchronizer
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int PRESCALE       = 1,
  parameter bit BASE_CAUSE_MSB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        ext_irq,
  output logic        irq,
  output logic [31:0] irq_cause,
  input  logic        trap_ack,
  input  logic        trap_ret
);
  state_t      state;
  logic        msip, ext_pend, ext_s, ext_prev, timer_pend, wr, ext_clr;
  logic [2:0]  enable, pend;
  logic [31:0] rd_val;
  logic [63:0] mtime, mtimecmp;
  assign wr = bus_req && bus_we;
  intc_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr),
    .wr_addr  (bus_addr),
    .wr_data  (bus_wdata),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .pending  (timer_pend)
  );
`ifdef INTC_EXT_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer for the asynchronous ext_irq line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else sync <= {sync[0], ext_irq};
  end
  assign ext_s = sync[1];
`else
  assign ext_s = ext_irq;
`endif
  // edge flop and ext pending; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_prev <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      ext_prev <= ext_s;
      ext_pend <= (ext_s && !ext_prev) || (ext_pend && !ext_clr);
    end
  end
  assign ext_clr = (wr && bus_addr == ADDR_EXT && bus_wdata[0]) ||
                   (state == REQ && trap_ack && irq_cause[30:0] == CAUSE_EXT);
  assign pend = {ext_pend, timer_pend, msip} & enable;
  assign rd_val = bus_addr == ADDR_MSIP    ? {31'b0, msip} :
                  bus_addr == ADDR_EXT     ? {31'b0, ext_pend} :
                  bus_addr == ADDR_CMP_LO  ? mtimecmp[31:0] :
                  bus_addr == ADDR_CMP_HI  ? mtimecmp[63:32] :
                  bus_addr == ADDR_TIME_LO ? mtime[31:0] :
                  bus_addr == ADDR_TIME_HI ? mtime[63:32] :
                  bus_addr == ADDR_EN      ? {29'b0, enable} : 32'b0;
  // one-cycle bus response and control register writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      msip      <= 1'b0;
      enable    <= '0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= bus_req ? rd_val : '0;
      if (wr && bus_addr == ADDR_MSIP) msip <= bus_wdata[0];
      if (wr && bus_addr == ADDR_EN) enable <= bus_wdata[2:0];
    end
  end
  // delivery FSM: request while any enabled pending, hold off during the handler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          state     <= REQ;
          irq       <= 1'b1;
          irq_cause <= {BASE_CAUSE_MSB, top_cause(pend)};
        end
        REQ: if (trap_ack) begin
          state <= TRAP;
          irq   <= 1'b0;
        end else if (!(|pend)) begin
          state <= IDLE;
          irq   <= 1'b0;
        end else irq_cause <= {BASE_CAUSE_MSB, top_cause(pend)};
        TRAP: if (trap_ret) state <= IDLE;
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end
endmodule
